// File: rtl/dic_load_ctrl.sv
// dic_load_ctrl
//   Turns one-cycle ASCII key strobes into digit-load sequences for the
//   clock datapath. It can load either the time counters or the alarm
//   registers. It also owns the run/freeze bit and the LED-digit advance
//   pulse.
// Ports
//   clk, rst           : clock, async active-high reset
//   key_valid/key_code : one-cycle key strobe and its ASCII code
//   dicRun             : 1 = clock counts, 0 = frozen
//   dicSelectLEDdisp   : one-cycle LED digit advance
//   ld_time, ld_alarm  : load-target levels (never both high)
//   ldMtens..ldSones   : one-cycle digit-load strobes
//   ld_num             : digit value, holds its last value
//   load_busy          : in a digit-load state
// Every output is a flop. Any response to a key seen in cycle N appears in N+1.
module dic_load_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       dicRun,
  output logic       dicSelectLEDdisp,
  output logic       ld_time,
  output logic       ld_alarm,
  output logic       ldMtens,
  output logic       ldMones,
  output logic       ldStens,
  output logic       ldSones,
  output logic [3:0] ld_num,
  output logic       load_busy
);

  typedef enum logic [2:0] {IDLE, LD_MT, LD_MO, LD_ST, LD_SO} state_t;

  localparam logic [7:0] KEY_L   = 8'h6C;
  localparam logic [7:0] KEY_A   = 8'h61;
  localparam logic [7:0] KEY_P   = 8'h70;
  localparam logic [7:0] KEY_N   = 8'h6E;
  localparam logic [7:0] KEY_ESC = 8'h1B;

  state_t     state, stateNxt;
  logic       mode, modeNxt;          // 0 = time, 1 = alarm
  logic       runNxt, selNxt;
  logic [3:0] ldNxt;                  // {Mtens, Mones, Stens, Sones}
  logic [3:0] numNxt;
  logic       timeNxt, alarmNxt;

  logic       isDigit;
  logic [3:0] digit;
  logic       le5;

  assign isDigit = (key_code >= 8'h30) && (key_code <= 8'h39);
  assign digit   = key_code[3:0];
  assign le5     = isDigit && (digit <= 4'd5);

  // State register, together with the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      mode             <= 1'b0;
      dicRun           <= 1'b1;
      dicSelectLEDdisp <= 1'b0;
      {ldMtens, ldMones, ldStens, ldSones} <= 4'b0;
      ld_num           <= 4'd0;
      ld_time          <= 1'b0;
      ld_alarm         <= 1'b0;
      load_busy        <= 1'b0;
    end else begin
      state            <= stateNxt;
      mode             <= modeNxt;
      dicRun           <= runNxt;
      dicSelectLEDdisp <= selNxt;
      {ldMtens, ldMones, ldStens, ldSones} <= ldNxt;
      ld_num           <= numNxt;
      ld_time          <= timeNxt;
      ld_alarm         <= alarmNxt;
      load_busy        <= (stateNxt != IDLE);
    end
  end

  // Next state. Keys that are not listed fall through and leave
  // everything unchanged.
  always_comb begin
    stateNxt = state;
    modeNxt  = mode;
    if (key_valid) begin
      unique case (state)
        IDLE: begin
          if (key_code == KEY_L) begin
            stateNxt = LD_MT;
            modeNxt  = 1'b0;
          end else if (key_code == KEY_A) begin
            stateNxt = LD_MT;
            modeNxt  = 1'b1;
          end
        end
        LD_MT: if (key_code == KEY_ESC) stateNxt = IDLE; else if (le5)     stateNxt = LD_MO;
        LD_MO: if (key_code == KEY_ESC) stateNxt = IDLE; else if (isDigit) stateNxt = LD_ST;
        LD_ST: if (key_code == KEY_ESC) stateNxt = IDLE; else if (le5)     stateNxt = LD_SO;
        LD_SO: if (key_code == KEY_ESC) stateNxt = IDLE; else if (isDigit) stateNxt = IDLE;
        default: stateNxt = IDLE;
      endcase
    end
  end

  // Output values for the next cycle.
  always_comb begin
    runNxt = dicRun;
    selNxt = 1'b0;
    ldNxt  = 4'b0;
    numNxt = ld_num;
    if (key_valid) begin
      unique case (state)
        IDLE: begin
          if (key_code == KEY_L)      runNxt = 1'b0;
          else if (key_code == KEY_P) runNxt = ~dicRun;
          else if (key_code == KEY_N) selNxt = 1'b1;
        end
        LD_MT: if (key_code != KEY_ESC && le5)     begin ldNxt = 4'b1000; numNxt = digit; end
        LD_MO: if (key_code != KEY_ESC && isDigit) begin ldNxt = 4'b0100; numNxt = digit; end
        LD_ST: if (key_code != KEY_ESC && le5)     begin ldNxt = 4'b0010; numNxt = digit; end
        LD_SO: if (key_code != KEY_ESC && isDigit) begin ldNxt = 4'b0001; numNxt = digit; end
        default: ;
      endcase
    end
    // A time load resumes the clock when it ends, whether it completes or
    // is aborted. An alarm load never touches dicRun, because 'p' is
    // ignored while a load is in progress.
    if (state != IDLE && stateNxt == IDLE && !mode)
      runNxt = 1'b1;
    // The target level stays high through the final ldSones cycle.
    timeNxt  = ((stateNxt != IDLE) || ldNxt[0]) && !modeNxt;
    alarmNxt = ((stateNxt != IDLE) || ldNxt[0]) &&  modeNxt;
  end

endmodule

// File: tb/tb_dic_load_ctrl.sv
module tb_dic_load_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_code;
  logic       dicRun, dicSelectLEDdisp, ld_time, ld_alarm;
  logic       ldMtens, ldMones, ldStens, ldSones, load_busy;
  logic [3:0] ld_num;

  dic_load_ctrl dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .dicRun(dicRun), .dicSelectLEDdisp(dicSelectLEDdisp),
    .ld_time(ld_time), .ld_alarm(ld_alarm),
    .ldMtens(ldMtens), .ldMones(ldMones), .ldStens(ldStens), .ldSones(ldSones),
    .ld_num(ld_num), .load_busy(load_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: phase 0 = idle, 1..4 = index of the digit awaited next.
  int   phase = 0;
  logic mMode = 0;
  logic mRun  = 1;
  logic [3:0] mNum = 0;
  logic [3:0] eLd;
  logic eSel, eTime, eAlarm;
  int   lim[4] = '{5, 9, 5, 9};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".run"},   32'(dicRun), 32'(mRun));
    chk({tag, ".sel"},   32'(dicSelectLEDdisp), 32'(eSel));
    chk({tag, ".ld"},    32'({ldMtens, ldMones, ldStens, ldSones}), 32'(eLd));
    chk({tag, ".num"},   32'(ld_num), 32'(mNum));
    chk({tag, ".time"},  32'(ld_time), 32'(eTime));
    chk({tag, ".alarm"}, 32'(ld_alarm), 32'(eAlarm));
    chk({tag, ".busy"},  32'(load_busy), 32'(phase != 0));
  endtask

  task automatic modelReset();
    phase = 0; mMode = 0; mRun = 1; mNum = 0;
    eLd = 0; eSel = 0; eTime = 0; eAlarm = 0;
  endtask

  // Applies one key cycle (or an idle cycle when v = 0) and checks the
  // response one cycle later.
  task automatic step(input string tag, input logic v, input logic [7:0] c);
    logic fin;
    fin = 0; eLd = 0; eSel = 0;
    if (v) begin
      if (phase == 0) begin
        if (c == "l")      begin phase = 1; mMode = 0; mRun = 0; end
        else if (c == "a") begin phase = 1; mMode = 1; end
        else if (c == "p") mRun = !mRun;
        else if (c == "n") eSel = 1;
      end else if (c == 8'h1B) begin
        phase = 0;
        if (!mMode) mRun = 1;
      end else if (int'(c) >= 48 && int'(c) <= 48 + lim[phase-1]) begin
        mNum = c[3:0];
        eLd[4-phase] = 1'b1;
        fin = (phase == 4);
        phase = fin ? 0 : phase + 1;
        if (fin && !mMode) mRun = 1;
      end
    end
    eTime  = (phase != 0 || fin) && !mMode;
    eAlarm = (phase != 0 || fin) &&  mMode;
    key_valid = v;
    key_code  = c;
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    rst = 1; key_valid = 0; key_code = 0;
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clk); rst = 0;
    step("idle0", 0, 0);

    // Time load 12:34
    step("l",   1, "l");
    step("t1",  1, "1");
    step("t2",  1, "2");
    step("t3",  1, "3");
    step("t4",  1, "4");
    step("tEnd", 0, 0);

    // Alarm load 59:59
    step("a",   1, "a");
    step("a5",  1, "5");
    step("a9",  1, "9");
    step("a5b", 1, "5");
    step("a9b", 1, "9");
    step("aEnd", 0, 0);

    // Range filtering
    step("l2",  1, "l");
    step("r7",  1, "7");
    step("rx",  1, "x");
    step("r3",  1, "3");
    step("rn",  1, "n");
    step("r9",  1, "9");
    step("r6",  1, "6");
    step("r0",  1, "0");
    step("rEsc", 1, 8'h1B);

    // Abort after one digit
    step("l3",  1, "l");
    step("e2",  1, "2");
    step("esc", 1, 8'h1B);
    step("escN", 0, 0);

    // Run toggle and held 'n'
    step("p1",  1, "p");
    step("p2",  1, "p");
    step("n1",  1, "n");
    step("n2",  1, "n");
    step("n3",  1, "n");
    step("nEnd", 0, 0);

    // Asynchronous reset in the middle of a load
    step("l4",  1, "l");
    step("m1",  1, "1");
    step("m2",  1, "2");
    key_valid = 0;
    #2 rst = 1;
    #1;
    modelReset();
    checkAll("rstMid");
    @(negedge clk); rst = 0;
    step("post5", 1, "5");

    // Randomized keys, biased toward the keys that matter
    for (int i = 0; i < 400; i++) begin
      logic [7:0] c;
      logic [7:0] pick[10];
      pick = '{"l", "a", "p", "n", 8'h1B, "0", "5", "6", "9", "x"};
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pick[$urandom_range(0, 9)];
      step("rand", 1'($urandom_range(0, 4) != 0), c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dic_load_ctrl.md
# dic_load_ctrl

Keyboard-driven controller for the digital-clock datapath. It decodes one-cycle ASCII key strobes and sequences digit loads into the time counters or the alarm registers. Each load goes through the datapath's `ld_time`/`ld_alarm`, `ldMtens..ldSones` and `ld_num` inputs. It also owns the run/freeze control (`dicRun`) and the LED-digit advance strobe (`dicSelectLEDdisp`). It sits between the UART/keypad receiver and the clock datapath.

## Interface
- Parameters: none.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid this cycle.
- `key_code`  in  8  ASCII code of the pressed key.
- `dicRun`  out  1  1 = clock counts, 0 = frozen.
- `dicSelectLEDdisp`  out  1  one-cycle pulse: advance LED digit select.
- `ld_time`  out  1  level: time-load mode active.
- `ld_alarm`  out  1  level: alarm-load mode active.
- `ldMtens`, `ldMones`, `ldStens`, `ldSones`  out  1 each  one-cycle digit-load pulse, at most one high per cycle.
- `ld_num`  out  4  digit value; holds its last loaded value.
- `load_busy`  out  1  high in any LD_* state.

## Operation
- States: IDLE, LD_MT, LD_MO, LD_ST, LD_SO. Internal bit `mode`: 0 = time, 1 = alarm.
- Keys are acted on only in the cycle `key_valid` = 1; `key_code` is ignored otherwise.
- Every unlisted key, in every state, is ignored. Ignored means no state change and no pulses.
- IDLE:
  - 'l' (0x6C): mode = time, go to LD_MT, `dicRun` ← 0.
  - 'a' (0x61): mode = alarm, go to LD_MT, `dicRun` unchanged.
  - 'p' (0x70): toggle `dicRun`.
  - 'n' (0x6E): pulse `dicSelectLEDdisp`.
- LD_* states accept ASCII digits '0'–'9' (0x30–0x39) with per-digit limits:
  - LD_MT: 0–5.
  - LD_MO: 0–9.
  - LD_ST: 0–5.
  - LD_SO: 0–9.
- Accepted digit:
  - `ld_num` ← code[3:0].
  - Pulse the matching `ldX`.
  - Advance LD_MT→LD_MO→LD_ST→LD_SO→IDLE.
- Out-of-range digit or non-digit: ignored, stay in the current state.
- ESC (0x1B) in any LD_* state aborts to IDLE. Digits already loaded remain in the datapath.
- On leaving time-load, whether completed or aborted, `dicRun` ← 1.
- On leaving alarm-load, `dicRun` keeps the value it had on entry.
- `ld_time` = (state ≠ IDLE) & ~mode.
- `ld_alarm` = (state ≠ IDLE) & mode.
- `ld_time` and `ld_alarm` are never both high.
- `ld_time`/`ld_alarm` stay high for the cycle carrying the final `ldSones` pulse and drop the next cycle.
- In LD_* states, 'p' and 'n' are ignored.

## Timing
- All outputs are registered.
- Response to a key strobe in cycle N appears in cycle N+1. This covers the state change, the `ldX` pulse, `ld_num`, the `dicRun` change and the `dicSelectLEDdisp` pulse.
- `ldX` and `dicSelectLEDdisp` are exactly one cycle wide, even if `key_valid` is held high. Each high cycle of `key_valid` counts as a new key.
- Back-to-back strobes in N and N+1 are both processed. Their responses appear at N+1 and N+2.
- `ld_num` is valid in the same cycle as its `ldX` pulse and holds afterwards.
- Reset values:
  - state IDLE, mode 0.
  - `dicRun` = 1.
  - `ld_time`, `ld_alarm`, all `ldX`, `dicSelectLEDdisp`, `load_busy` = 0.
  - `ld_num` = 0.
- Reset asserted mid-load forces the reset values immediately, asynchronously. No partial pulse is emitted after release.
- There is no interaction with the one-second strobe. During time-load the datapath is frozen by `dicRun` = 0, so `ldX`/`ce` never collides with a roll.

## Test plan
- Reset, then key 'l' followed by '1','2','3','4':
  - `ld_time` is high from the cycle after 'l'.
  - `dicRun` = 0 during the load.
  - `ldMtens` pulses with `ld_num`=1, then `ldMones`/2, `ldStens`/3, `ldSones`/4.
  - Then IDLE, `dicRun` = 1, clock reads 12:34 and counts.
- Key 'a' followed by '5','9','5','9':
  - `ld_alarm` is high throughout; `dicRun` stays 1.
  - Alarm registers read 59:59; time counters are unaffected.
- In LD_MT, keys '7', 'x', '3': only '3' is accepted (`ldMtens`, `ld_num`=3).
  - In LD_ST, '6' is ignored and '0' is accepted.
- Key 'l', then '2', then ESC:
  - `ldMtens` pulses once, then IDLE.
  - `ld_time`=0 and `dicRun`=1 the cycle after ESC.
  - Mtens = 2, other digits unchanged.
- In IDLE, 'p' gives `dicRun` 1→0; 'p' again gives 0→1.
  - 'n' held on `key_valid` for 3 cycles gives three 1-cycle `dicSelectLEDdisp` pulses.
  - 'n' during LD_MO gives no pulse.
- Key 'l', '1', '2', then `rst` asserted mid-cycle:
  - Outputs go immediately to the reset values (`dicRun`=1, `ld_time`=0, `ld_num`=0).
  - A later digit key is ignored in IDLE.
